matrix_loader: RTL and testbench

//  Upstream input stage of the parallel matrix multiplier. It accepts matrix A
//  and matrix B as one valid/ready element stream and writes them into main

---
 rtl/matrix_loader.sv | 154 +++++++++++++++
 tb/tb_matrix_loader.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_loader.sv
// matrix_loader: input stage of the parallel matrix multiplier.
// Takes A (row-major) followed by B (row-major) as one valid/ready stream and
// writes them to main memory: A row-major at A_BASE, B column-major at B_BASE.
// Then it pulses start and waits for the multiplier's done.
`timescale 1ns/1ps

module matrix_loader #(
    parameter int ROW_A         = 2,
    parameter int COMMON_FACTOR = 2,
    parameter int COLUMN_B      = 2,
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 10,
    parameter int A_BASE        = 0,
    parameter int B_BASE        = 512
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_req,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  getting_input,
    start,
    input  logic                  mult_done,
    output logic                  busy
);

    // Counters must hold the largest matrix dimension minus one.
    localparam int MAX_AB  = (ROW_A > COMMON_FACTOR) ? ROW_A : COMMON_FACTOR;
    localparam int MAX_DIM = (MAX_AB > COLUMN_B) ? MAX_AB : COLUMN_B;
    localparam int CNT_W   = $clog2(MAX_DIM + 1);

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t A_ROW_LAST = cnt_t'(ROW_A - 1);
    localparam cnt_t A_COL_LAST = cnt_t'(COMMON_FACTOR - 1);
    localparam cnt_t B_ROW_LAST = cnt_t'(COMMON_FACTOR - 1);
    localparam cnt_t B_COL_LAST = cnt_t'(COLUMN_B - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        FLUSH,
        START,
        WAIT_DONE
    } state_t;

    state_t                  state;
    state_t                  next_state;
    cnt_t                    row_cnt;
    cnt_t                    col_cnt;
    logic                    accept;
    logic                    row_last;
    logic                    col_last;
    logic                    matrix_last;
    logic [ADDR_WIDTH-1:0]   elem_addr;

    assign accept = in_valid & in_ready;

    // Wrap detection for the (row, col) counters of whichever matrix is loading.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        row_last = 1'b0;
        col_last = 1'b0;
        if (state == LOAD_B) begin
            row_last = (row_cnt == B_ROW_LAST);
            col_last = (col_cnt == B_COL_LAST);
        end else begin
            row_last = (row_cnt == A_ROW_LAST);
            col_last = (col_cnt == A_COL_LAST);
        end
        matrix_last = row_last & col_last;
    end

    // Target address: A stays row-major, B is transposed so its columns are contiguous.
    always_comb begin
        if (state == LOAD_B) begin
            // B element (k=row_cnt, j=col_cnt) goes to B_BASE + j*COMMON_FACTOR + k.
            elem_addr = ADDR_WIDTH'(B_BASE)
                      + ADDR_WIDTH'(col_cnt) * ADDR_WIDTH'(COMMON_FACTOR)
                      + ADDR_WIDTH'(row_cnt);
        end else begin
            // A element (i=row_cnt, k=col_cnt) goes to A_BASE + i*COMMON_FACTOR + k.
            elem_addr = ADDR_WIDTH'(A_BASE)
                      + ADDR_WIDTH'(row_cnt) * ADDR_WIDTH'(COMMON_FACTOR)
                      + ADDR_WIDTH'(col_cnt);
        end
    end

    // Next-state decode for the load / start / wait sequence.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (load_req)              next_state = LOAD_A;
            LOAD_A:    if (accept && matrix_last) next_state = LOAD_B;
            LOAD_B:    if (accept && matrix_last) next_state = FLUSH;
            FLUSH:                                next_state = START;
            START:                                next_state = WAIT_DONE;
            WAIT_DONE: if (mult_done)             next_state = IDLE;
            default:                              next_state = IDLE;
        endcase
    end

    // State, registered Moore outputs, element counters and the registered write port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            row_cnt       <= '0;
            col_cnt       <= '0;
            in_ready      <= 1'b0;
            getting_input <= 1'b0;
            start         <= 1'b0;
            busy          <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state         <= next_state;
            // Outputs are decoded from next_state so the registered value matches the state it belongs to.
            in_ready      <= (next_state == LOAD_A) || (next_state == LOAD_B);
            getting_input <= (next_state == LOAD_A) || (next_state == LOAD_B) || (next_state == FLUSH);
            start         <= (next_state == START);
            busy          <= (next_state != IDLE);

            mem_we <= accept;
            if (accept) begin
                mem_addr  <= elem_addr;
                mem_wdata <= in_data;
            end

            if (next_state == IDLE) begin
                row_cnt <= '0;
                col_cnt <= '0;
            end else if (accept) begin
                if (matrix_last) begin
                    // Last element of a matrix: restart at (0,0) for the next one.
                    row_cnt <= '0;
                    col_cnt <= '0;
                end else if (col_last) begin
                    row_cnt <= row_cnt + 1'b1;
                    col_cnt <= '0;
                end else begin
                    col_cnt <= col_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_matrix_loader.sv
// tb_matrix_loader: randomized self-checking bench for matrix_loader.
// Three instances cover 2x2x2, 3x2x4 and 1x1x1 shapes. Expected memory images
// come from the placement rules applied to element indices.
`timescale 1ns/1ps

module tb_matrix_loader;

    localparam int DW     = 32;
    localparam int AW     = 10;
    localparam int A_BASE = 0;
    localparam int B_BASE = 512;

    int ra[3] = '{2, 3, 1};
    int cf[3] = '{2, 2, 1};
    int cb[3] = '{2, 4, 1};

    logic                clk   = 1'b0;
    logic                reset = 1'b1;
    logic [2:0]          load_req  = '0;
    logic [2:0]          in_valid  = '0;
    logic [2:0]          mult_done = '0;
    logic [2:0][DW-1:0]  in_data   = '0;
    wire  [2:0]          in_ready;
    wire  [2:0]          mem_we;
    wire  [2:0]          getting_input;
    wire  [2:0]          start;
    wire  [2:0]          busy;
    wire  [2:0][AW-1:0]  mem_addr;
    wire  [2:0][DW-1:0]  mem_wdata;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] tb_mem [3][1024];
    int we_cnt[3];
    int start_cnt[3];
    int gi_cnt[3];

    always #5 clk = ~clk;

    matrix_loader #(.ROW_A(2), .COMMON_FACTOR(2), .COLUMN_B(2), .DATA_WIDTH(DW),
                    .ADDR_WIDTH(AW), .A_BASE(A_BASE), .B_BASE(B_BASE)) u_dut0 (
        .clk(clk), .reset(reset), .load_req(load_req[0]), .in_valid(in_valid[0]),
        .in_data(in_data[0]), .in_ready(in_ready[0]), .mem_we(mem_we[0]),
        .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
        .getting_input(getting_input[0]), .start(start[0]),
        .mult_done(mult_done[0]), .busy(busy[0]));

    matrix_loader #(.ROW_A(3), .COMMON_FACTOR(2), .COLUMN_B(4), .DATA_WIDTH(DW),
                    .ADDR_WIDTH(AW), .A_BASE(A_BASE), .B_BASE(B_BASE)) u_dut1 (
        .clk(clk), .reset(reset), .load_req(load_req[1]), .in_valid(in_valid[1]),
        .in_data(in_data[1]), .in_ready(in_ready[1]), .mem_we(mem_we[1]),
        .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
        .getting_input(getting_input[1]), .start(start[1]),
        .mult_done(mult_done[1]), .busy(busy[1]));

    matrix_loader #(.ROW_A(1), .COMMON_FACTOR(1), .COLUMN_B(1), .DATA_WIDTH(DW),
                    .ADDR_WIDTH(AW), .A_BASE(A_BASE), .B_BASE(B_BASE)) u_dut2 (
        .clk(clk), .reset(reset), .load_req(load_req[2]), .in_valid(in_valid[2]),
        .in_data(in_data[2]), .in_ready(in_ready[2]), .mem_we(mem_we[2]),
        .mem_addr(mem_addr[2]), .mem_wdata(mem_wdata[2]),
        .getting_input(getting_input[2]), .start(start[2]),
        .mult_done(mult_done[2]), .busy(busy[2]));

    // Memory and pulse monitor, sampled mid-cycle.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (mem_we[d]) begin
                tb_mem[d][mem_addr[d]] <= mem_wdata[d];
                we_cnt[d] <= we_cnt[d] + 1;
            end
            if (start[d])         start_cnt[d] <= start_cnt[d] + 1;
            if (getting_input[d]) gi_cnt[d]    <= gi_cnt[d] + 1;
        end
    end

    // Element n of the stream: A elements first (row-major), then B (row-major).
    function automatic int exp_addr(input int d, input int n);
        int na;
        int m;
        na = ra[d] * cf[d];
        if (n < na) return (A_BASE + n) % 1024;
        m = n - na;
        // B element (k = m / cb, j = m % cb) is stored column-major.
        return (B_BASE + (m % cb[d]) * cf[d] + (m / cb[d])) % 1024;
    endfunction

    // One complete load: stream, flush, start, wait, done; then image and pulse counts.
    task automatic run_load(input int d, input int base, input int gap_pct,
                            input bit done_early, input bit probe_req,
                            input int abort_after, input string name);
        int total;
        int edges;
        int tries;
        bit acc;
        logic [DW-1:0] vals[$];
        total = ra[d] * cf[d] + cf[d] * cb[d];
        edges = 0;
        for (int n = 0; n < total; n++)
            vals.push_back(base > 0 ? DW'(base + n) : DW'($urandom));
        we_cnt[d] = 0;
        start_cnt[d] = 0;
        gi_cnt[d] = 0;
        mult_done[d] = done_early;

        load_req[d] = 1'b1;
        @(posedge clk); #1;
        load_req[d] = 1'b0;
        tests++;
        if (in_ready[d] !== 1'b1 || busy[d] !== 1'b1) begin
            fails++;
            $display("FAIL %s enter_load: in_ready=%b busy=%b, required 1 1", name, in_ready[d], busy[d]);
        end

        for (int n = 0; n < total; n++) begin
            for (int g = 0; g < 8 && $urandom_range(99) < gap_pct; g++) begin
                in_valid[d] = 1'b0;
                in_data[d]  = $urandom;
                @(posedge clk); #1;
                edges++;
            end
            in_valid[d] = 1'b1;
            in_data[d]  = vals[n];
            acc = 1'b0;
            tries = 0;
            while (!acc) begin
                acc = in_ready[d];
                @(posedge clk); #1;
                edges++;
                tries++;
                if (!acc && tries >= 16) begin
                    tests++;
                    fails++;
                    $display("FAIL %s accept_timeout: element %0d not accepted after %0d cycles, required accept", name, n, tries);
                    in_valid[d] = 1'b0;
                    return;
                end
            end
            if (n == abort_after) begin
                in_valid[d] = 1'b0;
                reset = 1'b1;
                #1;
                tests++;
                if ({in_ready[d], mem_we[d], getting_input[d], start[d], busy[d]} !== 5'b0 ||
                    mem_addr[d] !== '0 || mem_wdata[d] !== '0) begin
                    fails++;
                    $display("FAIL %s async_reset: rdy/we/gi/st/busy=%b addr=%0d wdata=%h, required all 0",
                             name, {in_ready[d], mem_we[d], getting_input[d], start[d], busy[d]},
                             mem_addr[d], mem_wdata[d]);
                end
                @(posedge clk); #1;
                reset = 1'b0;
                @(posedge clk); #1;
                tests++;
                if (busy[d] !== 1'b0 || we_cnt[d] !== abort_after) begin
                    fails++;
                    $display("FAIL %s reset_drop: busy=%b writes=%0d, required 0 %0d", name, busy[d], we_cnt[d], abort_after);
                end
                return;
            end
        end
        in_valid[d] = 1'b0;

        // Cycle after the last accept: FLUSH with the final write.
        tests++;
        if ({mem_we[d], getting_input[d], start[d]} !== 3'b110 ||
            mem_addr[d] !== AW'(exp_addr(d, total - 1)) || mem_wdata[d] !== vals[total - 1]) begin
            fails++;
            $display("FAIL %s flush: we/gi/st=%b addr=%0d wdata=%h, required 110 %0d %h", name,
                     {mem_we[d], getting_input[d], start[d]}, mem_addr[d], mem_wdata[d],
                     exp_addr(d, total - 1), vals[total - 1]);
        end
        @(posedge clk); #1;
        tests++;
        if ({mem_we[d], getting_input[d], start[d], busy[d]} !== 4'b0011) begin
            fails++;
            $display("FAIL %s start_cycle: we/gi/st/busy=%b, required 0011", name,
                     {mem_we[d], getting_input[d], start[d], busy[d]});
        end
        @(posedge clk); #1;
        tests++;
        if ({start[d], busy[d], in_ready[d]} !== 3'b010) begin
            fails++;
            $display("FAIL %s wait_entry: st/busy/rdy=%b, required 010", name, {start[d], busy[d], in_ready[d]});
        end

        if (done_early) begin
            @(posedge clk); #1;
            mult_done[d] = 1'b0;
            tests++;
            if (busy[d] !== 1'b0) begin
                fails++;
                $display("FAIL %s early_done_exit: busy=%b, required 0", name, busy[d]);
            end
        end else begin
            if (probe_req) begin
                load_req[d] = 1'b1;
                @(posedge clk); #1;
                load_req[d] = 1'b0;
                tests++;
                if ({busy[d], in_ready[d], getting_input[d]} !== 3'b100) begin
                    fails++;
                    $display("FAIL %s ignore_load_req: busy/rdy/gi=%b, required 100", name,
                             {busy[d], in_ready[d], getting_input[d]});
                end
            end
            repeat ($urandom_range(3)) begin
                @(posedge clk); #1;
            end
            tests++;
            if (busy[d] !== 1'b1) begin
                fails++;
                $display("FAIL %s hold_wait: busy=%b, required 1", name, busy[d]);
            end
            mult_done[d] = 1'b1;
            @(posedge clk); #1;
            mult_done[d] = 1'b0;
            tests++;
            if (busy[d] !== 1'b0) begin
                fails++;
                $display("FAIL %s done_exit: busy=%b, required 0", name, busy[d]);
            end
            @(posedge clk); #1;
            tests++;
            if ({busy[d], in_ready[d], getting_input[d]} !== 3'b000) begin
                fails++;
                $display("FAIL %s stay_idle: busy/rdy/gi=%b, required 000", name,
                         {busy[d], in_ready[d], getting_input[d]});
            end
        end

        for (int n = 0; n < total; n++) begin
            tests++;
            if (tb_mem[d][exp_addr(d, n)] !== vals[n]) begin
                fails++;
                $display("FAIL %s mem[%0d] (element %0d): got %h, required %h", name,
                         exp_addr(d, n), n, tb_mem[d][exp_addr(d, n)], vals[n]);
            end
        end
        tests++;
        if (we_cnt[d] !== total || start_cnt[d] !== 1 || gi_cnt[d] !== edges + 1) begin
            fails++;
            $display("FAIL %s pulse_counts: writes=%0d starts=%0d gi_cycles=%0d, required %0d 1 %0d",
                     name, we_cnt[d], start_cnt[d], gi_cnt[d], total, edges + 1);
        end
    endtask

    task automatic test_reset();
        #12;
        for (int d = 0; d < 3; d++) begin
            tests++;
            if ({in_ready[d], mem_we[d], getting_input[d], start[d], busy[d]} !== 5'b0 ||
                mem_addr[d] !== '0 || mem_wdata[d] !== '0) begin
                fails++;
                $display("FAIL reset_state dut%0d: rdy/we/gi/st/busy=%b addr=%0d wdata=%h, required all 0",
                         d, {in_ready[d], mem_we[d], getting_input[d], start[d], busy[d]},
                         mem_addr[d], mem_wdata[d]);
            end
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (busy !== 3'b000 || in_ready !== 3'b000) begin
            fails++;
            $display("FAIL reset_release: busy=%b in_ready=%b, required 000 000", busy, in_ready);
        end
    endtask

    task automatic test_stream_2x2x2();
        run_load(0, 1, 0, 1'b0, 1'b0, -1, "t1_2x2x2");
    endtask

    task automatic test_back_pressure();
        run_load(0, 1, 50, 1'b0, 1'b0, -1, "t2_gaps_fixed");
        run_load(0, 0, 60, 1'b0, 1'b0, -1, "t2_gaps_random");
    endtask

    task automatic test_3x2x4();
        run_load(1, 1, 0, 1'b0, 1'b0, -1, "t3_3x2x4");
        tests++;
        if (tb_mem[1][519] !== 32'd14) begin
            fails++;
            $display("FAIL t3_b13: mem[519]=%0d, required 14", tb_mem[1][519]);
        end
        run_load(1, 0, 30, 1'b0, 1'b0, -1, "t3_random");
    endtask

    task automatic test_reset_mid_load();
        run_load(0, 0, 20, 1'b0, 1'b0, 5, "t4_abort");
        run_load(0, 0, 0, 1'b0, 1'b0, -1, "t4_reload");
    endtask

    task automatic test_load_req_in_wait();
        run_load(0, 0, 30, 1'b0, 1'b1, -1, "t5_probe");
    endtask

    task automatic test_done_early();
        run_load(1, 0, 20, 1'b1, 1'b0, -1, "done_early");
    endtask

    task automatic test_1x1x1();
        run_load(2, 9, 0, 1'b0, 1'b0, -1, "t6_1x1x1");
    endtask

    task automatic test_back_to_back();
        run_load(2, 0, 40, 1'b0, 1'b0, -1, "b2b_first");
        run_load(2, 0, 40, 1'b1, 1'b0, -1, "b2b_second");
    endtask

    initial begin
        test_reset();
        test_stream_2x2x2();
        test_back_pressure();
        test_3x2x4();
        test_reset_mid_load();
        test_load_req_in_wait();
        test_done_early();
        test_1x1x1();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
